prog_ctr_stack: RTL and testbench
=================================

Name: prog_ctr_stack

Overview:
- Parametrised program counter for the 3BC processor core.
- Adds run control (IDLE/RUN/HALT), absolute jumps, signed relative branches, and a hardware return-address stack for call/return.
- Sits between the control decoder and the instruction ROM address port. ProgCtr drives the instruction fetch address directly.

Parameters:
- L, 10, PC and address width in bits.
- D, 4, return-stack depth in entries; minimum 1.
- DW, $clog2(D+1), width of the Depth output (derived; not overridden).

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  pulse; from IDLE or HALT, load StartAddr and enter RUN.
- StartAddr  in  L  program entry address.
- En  in  1  advance enable in RUN; 0 = stall (hold everything).
- Halt  in  1  in RUN, freeze PC and enter HALT.
- BranchEn  in  1  relative branch: PC <= PC + Offset.
- Offset  in  L  two's-complement branch offset.
- JumpEn  in  1  absolute jump: PC <= Target.
- Target  in  L  jump/call destination.
- CallEn  in  1  push PC+1, then PC <= Target.
- RetEn  in  1  pop top of stack into PC.
- ErrClr  in  1  clear sticky Overflow/Underflow.
- ProgCtr  out  L  program counter register.
- Running  out  1  state == RUN.
- Halted  out  1  state == HALT.
- Depth  out  DW  number of valid stack entries (0..D).
- Overflow  out  1  sticky; a call was attempted with a full stack.
- Underflow  out  1  sticky; a return was attempted with an empty stack.

Behaviour:
- Reset low, asynchronous: ProgCtr=0, state=IDLE, Depth=0, Overflow=0, Underflow=0, all stack entries=0.
- All outputs are registered; every update lands 1 cycle after the sampled inputs.
- State IDLE:
  - Start=1 -> RUN, ProgCtr<=StartAddr.
  - All other inputs are ignored and ProgCtr holds.
- State HALT:
  - Same as IDLE: Start=1 -> RUN, ProgCtr<=StartAddr.
  - Stack contents and Depth are preserved across HALT and restart.
- State RUN, highest priority first:
  1. Halt=1 -> HALT. PC holds, no stack operation, other controls ignored.
  2. En=0 -> stall. PC, stack and flags hold. ErrClr still acts.
  3. RetEn=1:
     - Depth>0: ProgCtr<=stack[top], Depth<=Depth-1.
     - Depth==0: ProgCtr<=ProgCtr+1, Underflow<=1.
  4. CallEn=1:
     - Depth<D: push ProgCtr+1, ProgCtr<=Target, Depth<=Depth+1.
     - Depth==D: no push, ProgCtr<=ProgCtr+1, Overflow<=1.
  5. JumpEn=1 -> ProgCtr<=Target.
  6. BranchEn=1 -> ProgCtr<=ProgCtr+Offset.
  7. Otherwise -> ProgCtr<=ProgCtr+1.
- Start while in RUN is ignored.
- Simultaneous controls resolve strictly by the priority above; for example, CallEn+RetEn in one cycle performs the return only.
- Arithmetic: all PC sums are modulo 2^L.
  - Offset is sign-interpreted, so 10'h3FF = -1.
  - Increment from 2^L-1 wraps to 0.
  - A pushed return address of 2^L-1 + 1 is stored as 0.
- Sticky flags:
  - Set only by the error conditions above.
  - Cleared by ErrClr=1 in any state.
  - If ErrClr and a new error occur in the same cycle, set wins.
- Stack organisation is LIFO. The top entry is stack[Depth-1]. Entries above Depth are don't-care and are never observable.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial push or pop survives.

Test Plan:
- Reset low; Start=1, StartAddr=10'h020; then 3 cycles of En=1 with no other controls -> ProgCtr 0, 0x020, 0x021, 0x022, 0x023; Running=1.
- At PC=0x040, BranchEn=1, Offset=10'h3FC -> PC=0x03C. At PC=0x3FF with plain increment -> PC=0x000.
- D=4, starting from PC=0x010: CallEn with Target 0x100, 0x200, 0x300 -> Depth=3, pushed entries 0x011, 0x101, 0x201. Three RetEn -> PC sequence 0x201, 0x101, 0x011; Depth=0.
- Call 5 times with D=4 -> 5th call gives PC+1, Overflow=1, Depth=4. RetEn 5 times -> 5th return gives Underflow=1. ErrClr -> both flags 0. ErrClr on the same cycle as an overflowing call -> Overflow stays 1.
- In RUN at PC=0x050: En=0 for 2 cycles -> PC stays 0x050. Halt=1 -> Halted=1, PC stays 0x050. Start=1, StartAddr=0x000 -> PC=0x000, Depth preserved.
- Reset pulsed low between clock edges while Depth=2 and PC=0x123 -> outputs go to 0 / IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prog_ctr_stack_if.sv
// rtl/prog_ctr_stack_if.sv - control and status bundle between decoder and program counter
// Ports (signals):
//   Start, StartAddr[L]            run entry request and address
//   En, Halt                       advance enable / halt request
//   BranchEn, Offset[L]            signed relative branch
//   JumpEn, Target[L]              absolute jump, also call destination
//   CallEn, RetEn, ErrClr          return-stack operations, sticky-flag clear
//   ProgCtr[L], Running, Halted    fetch address and run state
//   Depth[DW], Overflow, Underflow return-stack occupancy and sticky errors
// Modports: master drives controls (decoder side), slave drives status (program counter).
interface prog_ctr_stack_if #(
    parameter int L = 10,
    parameter int D = 4
);
    localparam int DW = $clog2(D + 1);

    logic          Start;
    logic [L-1:0]  StartAddr;
    logic          En;
    logic          Halt;
    logic          BranchEn;
    logic [L-1:0]  Offset;
    logic          JumpEn;
    logic [L-1:0]  Target;
    logic          CallEn;
    logic          RetEn;
    logic          ErrClr;
    logic [L-1:0]  ProgCtr;
    logic          Running;
    logic          Halted;
    logic [DW-1:0] Depth;
    logic          Overflow;
    logic          Underflow;

    modport master (
        output Start, StartAddr, En, Halt, BranchEn, Offset, JumpEn, Target,
               CallEn, RetEn, ErrClr,
        input  ProgCtr, Running, Halted, Depth, Overflow, Underflow
    );

    modport slave (
        input  Start, StartAddr, En, Halt, BranchEn, Offset, JumpEn, Target,
               CallEn, RetEn, ErrClr,
        output ProgCtr, Running, Halted, Depth, Overflow, Underflow
    );
endinterface

// File: rtl/prog_ctr_stack.sv
// rtl/prog_ctr_stack.sv - program counter with run control, branches and return-address stack
// Ports:
//   Clk    in  clock, all state changes on posedge
//   Reset  in  asynchronous active-low reset
//   bus    prog_ctr_stack_if.slave: controls in, ProgCtr/Running/Halted/Depth/flags out
module prog_ctr_stack #(
    parameter int L = 10,
    parameter int D = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    prog_ctr_stack_if.slave   bus
);
    localparam int DW = $clog2(D + 1);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(D);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t        r_state;
    logic [L-1:0]  r_pc;
    logic [DW-1:0] r_depth;
    logic          r_ovf;
    logic          r_unf;
    logic [L-1:0]  r_stack [D];

    state_t        w_state_nxt;
    logic [L-1:0]  w_pc_nxt;
    logic [DW-1:0] w_depth_nxt;
    logic          w_ovf_nxt;
    logic          w_unf_nxt;
    logic          w_push;
    logic [L-1:0]  w_pc_inc;
    logic [DW-1:0] w_top_idx;

    assign w_pc_inc  = r_pc + L'(1);
    assign w_top_idx = r_depth - DW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_depth_nxt = r_depth;
        // ErrClr acts in every state; an error raised below in the same cycle overrides it.
        w_ovf_nxt   = r_ovf & ~bus.ErrClr;
        w_unf_nxt   = r_unf & ~bus.ErrClr;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (bus.Start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = bus.StartAddr;
                end
            end
            ST_RUN: begin
                if (bus.Halt) begin
                    w_state_nxt = ST_HALT;
                end else if (bus.En) begin
                    if (bus.RetEn) begin
                        if (r_depth != '0) begin
                            w_pc_nxt    = r_stack[w_top_idx];
                            w_depth_nxt = w_top_idx;
                        end else begin
                            w_pc_nxt  = w_pc_inc;
                            w_unf_nxt = 1'b1;
                        end
                    end else if (bus.CallEn) begin
                        if (r_depth != DEPTH_FULL) begin
                            w_push      = 1'b1;
                            w_pc_nxt    = bus.Target;
                            w_depth_nxt = r_depth + DW'(1);
                        end else begin
                            w_pc_nxt  = w_pc_inc;
                            w_ovf_nxt = 1'b1;
                        end
                    end else if (bus.JumpEn) begin
                        w_pc_nxt = bus.Target;
                    end else if (bus.BranchEn) begin
                        w_pc_nxt = r_pc + bus.Offset;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < D; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            // Push slot is the current Depth, i.e. one above the present top entry.
            if (w_push) begin
                r_stack[r_depth] <= w_pc_inc;
            end
        end
    end

    assign bus.ProgCtr   = r_pc;
    assign bus.Running   = (r_state == ST_RUN);
    assign bus.Halted    = (r_state == ST_HALT);
    assign bus.Depth     = r_depth;
    assign bus.Overflow  = r_ovf;
    assign bus.Underflow = r_unf;
endmodule

// File: tb/tb_prog_ctr_stack.sv
// tb/tb_prog_ctr_stack.sv - directed self-checking bench for prog_ctr_stack
module tb_prog_ctr_stack;
    logic Clk;
    logic Reset;
    int   tests;
    int   fails;

    prog_ctr_stack_if #(.L(10), .D(4)) bus ();

    prog_ctr_stack #(.L(10), .D(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clr_ctl();
        bus.Start = 1'b0; bus.StartAddr = '0; bus.En = 1'b0; bus.Halt = 1'b0;
        bus.BranchEn = 1'b0; bus.Offset = '0; bus.JumpEn = 1'b0; bus.Target = '0;
        bus.CallEn = 1'b0; bus.RetEn = 1'b0; bus.ErrClr = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (bus.ProgCtr !== 10'h000) begin fails++; $display("FAIL reset_pc got %h exp 000", bus.ProgCtr); end
        tests++; if (bus.Running !== 1'b0) begin fails++; $display("FAIL reset_running got %b exp 0", bus.Running); end
        tests++; if (bus.Halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", bus.Halted); end
        tests++; if (bus.Depth !== 3'd0) begin fails++; $display("FAIL reset_depth got %0d exp 0", bus.Depth); end
        tests++; if (bus.Overflow !== 1'b0 || bus.Underflow !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b exp 00", bus.Overflow, bus.Underflow); end
        @(negedge Clk);
        Reset = 1'b1;
        step();
        // IDLE ignores everything but Start
        clr_ctl(); bus.En = 1'b1; bus.JumpEn = 1'b1; bus.Target = 10'h155;
        step();
        tests++; if (bus.ProgCtr !== 10'h000) begin fails++; $display("FAIL idle_hold_pc got %h exp 000", bus.ProgCtr); end
        tests++; if (bus.Running !== 1'b0) begin fails++; $display("FAIL idle_running got %b exp 0", bus.Running); end
    endtask

    task automatic test_start_increment();
        clr_ctl(); bus.Start = 1'b1; bus.StartAddr = 10'h020;
        step();
        tests++; if (bus.ProgCtr !== 10'h020) begin fails++; $display("FAIL start_pc got %h exp 020", bus.ProgCtr); end
        tests++; if (bus.Running !== 1'b1) begin fails++; $display("FAIL start_running got %b exp 1", bus.Running); end
        clr_ctl(); bus.En = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests++; if (bus.ProgCtr !== 10'(10'h020 + i)) begin fails++; $display("FAIL incr_pc[%0d] got %h exp %h", i, bus.ProgCtr, 10'(10'h020 + i)); end
        end
    endtask

    task automatic test_branch_jump();
        clr_ctl(); bus.En = 1'b1; bus.JumpEn = 1'b1; bus.Target = 10'h040;
        step();
        tests++; if (bus.ProgCtr !== 10'h040) begin fails++; $display("FAIL jump_pc got %h exp 040", bus.ProgCtr); end
        clr_ctl(); bus.En = 1'b1; bus.BranchEn = 1'b1; bus.Offset = 10'h3FC;
        step();
        tests++; if (bus.ProgCtr !== 10'h03C) begin fails++; $display("FAIL branch_neg got %h exp 03c", bus.ProgCtr); end
        bus.Offset = 10'h005;
        step();
        tests++; if (bus.ProgCtr !== 10'h041) begin fails++; $display("FAIL branch_pos got %h exp 041", bus.ProgCtr); end
        clr_ctl(); bus.En = 1'b1; bus.JumpEn = 1'b1; bus.Target = 10'h3FF;
        step();
        clr_ctl(); bus.En = 1'b1;
        step();
        tests++; if (bus.ProgCtr !== 10'h000) begin fails++; $display("FAIL incr_wrap got %h exp 000", bus.ProgCtr); end
        bus.JumpEn = 1'b1; bus.Target = 10'h010; bus.BranchEn = 1'b1; bus.Offset = 10'h005;
        step();
        tests++; if (bus.ProgCtr !== 10'h010) begin fails++; $display("FAIL jump_over_branch got %h exp 010", bus.ProgCtr); end
    endtask

    task automatic test_call_ret();
        logic [9:0] tgt [3];
        logic [9:0] ret [3];
        tgt[0] = 10'h100; tgt[1] = 10'h200; tgt[2] = 10'h300;
        ret[0] = 10'h201; ret[1] = 10'h101; ret[2] = 10'h011;
        for (int i = 0; i < 3; i++) begin
            clr_ctl(); bus.En = 1'b1; bus.CallEn = 1'b1; bus.Target = tgt[i];
            step();
            tests++; if (bus.ProgCtr !== tgt[i] || bus.Depth !== 3'(i + 1)) begin fails++; $display("FAIL call[%0d] pc/depth got %h/%0d exp %h/%0d", i, bus.ProgCtr, bus.Depth, tgt[i], i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            clr_ctl(); bus.En = 1'b1; bus.RetEn = 1'b1;
            step();
            tests++; if (bus.ProgCtr !== ret[i] || bus.Depth !== 3'(2 - i)) begin fails++; $display("FAIL ret[%0d] pc/depth got %h/%0d exp %h/%0d", i, bus.ProgCtr, bus.Depth, ret[i], 2 - i); end
        end
        tests++; if (bus.Overflow !== 1'b0 || bus.Underflow !== 1'b0) begin fails++; $display("FAIL callret_flags got %b%b exp 00", bus.Overflow, bus.Underflow); end
    endtask

    task automatic test_overflow_underflow();
        logic [9:0] ret [4];
        ret[0] = 10'h101; ret[1] = 10'h101; ret[2] = 10'h101; ret[3] = 10'h012;
        clr_ctl(); bus.En = 1'b1; bus.CallEn = 1'b1; bus.Target = 10'h100;
        for (int i = 0; i < 4; i++) step();
        tests++; if (bus.ProgCtr !== 10'h100 || bus.Depth !== 3'd4) begin fails++; $display("FAIL fill pc/depth got %h/%0d exp 100/4", bus.ProgCtr, bus.Depth); end
        step();
        tests++; if (bus.ProgCtr !== 10'h101) begin fails++; $display("FAIL ovf_pc got %h exp 101", bus.ProgCtr); end
        tests++; if (bus.Overflow !== 1'b1 || bus.Depth !== 3'd4) begin fails++; $display("FAIL ovf flag/depth got %b/%0d exp 1/4", bus.Overflow, bus.Depth); end
        clr_ctl(); bus.En = 1'b1; bus.RetEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (bus.ProgCtr !== ret[i]) begin fails++; $display("FAIL drain_ret[%0d] got %h exp %h", i, bus.ProgCtr, ret[i]); end
        end
        tests++; if (bus.Depth !== 3'd0 || bus.Underflow !== 1'b0) begin fails++; $display("FAIL drain depth/unf got %0d/%b exp 0/0", bus.Depth, bus.Underflow); end
        step();
        tests++; if (bus.ProgCtr !== 10'h013 || bus.Underflow !== 1'b1) begin fails++; $display("FAIL unf pc/flag got %h/%b exp 013/1", bus.ProgCtr, bus.Underflow); end
        tests++; if (bus.Overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", bus.Overflow); end
        clr_ctl(); bus.En = 1'b1; bus.ErrClr = 1'b1;
        step();
        tests++; if (bus.Overflow !== 1'b0 || bus.Underflow !== 1'b0 || bus.ProgCtr !== 10'h014) begin fails++; $display("FAIL errclr flags/pc got %b%b/%h exp 00/014", bus.Overflow, bus.Underflow, bus.ProgCtr); end
        clr_ctl(); bus.En = 1'b1; bus.CallEn = 1'b1; bus.Target = 10'h200;
        for (int i = 0; i < 4; i++) step();
        bus.Target = 10'h300; bus.ErrClr = 1'b1;
        step();
        tests++; if (bus.Overflow !== 1'b1 || bus.ProgCtr !== 10'h201) begin fails++; $display("FAIL set_beats_clr flag/pc got %b/%h exp 1/201", bus.Overflow, bus.ProgCtr); end
        clr_ctl(); bus.ErrClr = 1'b1;
        step();
        tests++; if (bus.Overflow !== 1'b0 || bus.ProgCtr !== 10'h201) begin fails++; $display("FAIL clr_in_stall flag/pc got %b/%h exp 0/201", bus.Overflow, bus.ProgCtr); end
        clr_ctl(); bus.En = 1'b1; bus.CallEn = 1'b1; bus.RetEn = 1'b1; bus.Target = 10'h300;
        step();
        tests++; if (bus.ProgCtr !== 10'h201 || bus.Depth !== 3'd3 || bus.Overflow !== 1'b0) begin fails++; $display("FAIL call_ret_prio pc/depth/ovf got %h/%0d/%b exp 201/3/0", bus.ProgCtr, bus.Depth, bus.Overflow); end
        clr_ctl(); bus.En = 1'b1; bus.RetEn = 1'b1;
        step(); step(); step();
        tests++; if (bus.ProgCtr !== 10'h015 || bus.Depth !== 3'd0) begin fails++; $display("FAIL final_pop pc/depth got %h/%0d exp 015/0", bus.ProgCtr, bus.Depth); end
    endtask

    task automatic test_stall_halt();
        clr_ctl(); bus.En = 1'b1; bus.CallEn = 1'b1; bus.Target = 10'h050;
        step();
        clr_ctl(); bus.CallEn = 1'b1; bus.Target = 10'h3AA;
        step(); step();
        tests++; if (bus.ProgCtr !== 10'h050 || bus.Depth !== 3'd1) begin fails++; $display("FAIL stall pc/depth got %h/%0d exp 050/1", bus.ProgCtr, bus.Depth); end
        clr_ctl(); bus.Halt = 1'b1; bus.En = 1'b1; bus.CallEn = 1'b1; bus.Target = 10'h3AA;
        step();
        tests++; if (bus.Halted !== 1'b1 || bus.Running !== 1'b0) begin fails++; $display("FAIL halt state got H%b R%b exp H1 R0", bus.Halted, bus.Running); end
        tests++; if (bus.ProgCtr !== 10'h050 || bus.Depth !== 3'd1) begin fails++; $display("FAIL halt pc/depth got %h/%0d exp 050/1", bus.ProgCtr, bus.Depth); end
        clr_ctl(); bus.En = 1'b1; bus.JumpEn = 1'b1; bus.Target = 10'h111;
        step();
        tests++; if (bus.ProgCtr !== 10'h050 || bus.Halted !== 1'b1) begin fails++; $display("FAIL halt_ignore pc/halted got %h/%b exp 050/1", bus.ProgCtr, bus.Halted); end
        clr_ctl(); bus.Start = 1'b1; bus.StartAddr = 10'h000;
        step();
        tests++; if (bus.ProgCtr !== 10'h000 || bus.Running !== 1'b1 || bus.Halted !== 1'b0) begin fails++; $display("FAIL restart pc/R/H got %h/%b/%b exp 000/1/0", bus.ProgCtr, bus.Running, bus.Halted); end
        tests++; if (bus.Depth !== 3'd1) begin fails++; $display("FAIL restart_depth got %0d exp 1", bus.Depth); end
        clr_ctl(); bus.Start = 1'b1; bus.StartAddr = 10'h300; bus.En = 1'b1;
        step();
        tests++; if (bus.ProgCtr !== 10'h001) begin fails++; $display("FAIL start_in_run got %h exp 001", bus.ProgCtr); end
    endtask

    task automatic test_async_reset();
        clr_ctl(); bus.En = 1'b1; bus.CallEn = 1'b1; bus.Target = 10'h123;
        step();
        tests++; if (bus.ProgCtr !== 10'h123 || bus.Depth !== 3'd2) begin fails++; $display("FAIL pre_reset pc/depth got %h/%0d exp 123/2", bus.ProgCtr, bus.Depth); end
        clr_ctl();
        #2;
        Reset = 1'b0;
        #1;
        tests++; if (bus.ProgCtr !== 10'h000 || bus.Depth !== 3'd0) begin fails++; $display("FAIL async_reset pc/depth got %h/%0d exp 000/0", bus.ProgCtr, bus.Depth); end
        tests++; if (bus.Running !== 1'b0 || bus.Halted !== 1'b0) begin fails++; $display("FAIL async_reset state got R%b H%b exp R0 H0", bus.Running, bus.Halted); end
        @(negedge Clk);
        Reset = 1'b1;
        bus.Start = 1'b1; bus.StartAddr = 10'h020;
        step();
        clr_ctl(); bus.En = 1'b1; bus.RetEn = 1'b1;
        step();
        tests++; if (bus.ProgCtr !== 10'h021 || bus.Underflow !== 1'b1 || bus.Depth !== 3'd0) begin fails++; $display("FAIL post_reset_ret pc/unf/depth got %h/%b/%0d exp 021/1/0", bus.ProgCtr, bus.Underflow, bus.Depth); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Reset = 1'b0;
        clr_ctl();
        test_reset();
        test_start_increment();
        test_branch_jump();
        test_call_ret();
        test_overflow_underflow();
        test_stall_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
